// File: rtl/mem_access.sv
// Memory-access stage of the RV32I pipeline. Issues loads and stores over a
// request/acknowledge data-memory port, formats load data, and hands results
// to writeback. The ALU stage is held off while an access is outstanding.
//
// Handshake: dmem_req is raised with addr/we/wdata/wstrb and all of them
// stay stable until a cycle in which dmem_ack is high. That cycle completes
// the transfer, and dmem_rdata is sampled in it. An ack seen while no
// request is pending is ignored.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module mem_access (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`OPCODE_WIDTH-1:0] prev_opcode_type,
  input  logic                     stall_from_alu,
  input  logic [31:0]              prev_alu_result,
  input  logic [31:0]              prev_rs2_data,
  input  logic [2:0]               prev_funct3,
  input  logic [4:0]               prev_rd,
  input  logic [31:0]              prev_rd_wdata,
  input  logic                     prev_rd_w_en,
  input  logic [31:0]              prev_pc,
  input  logic                     prev_clk_en,
  input  logic                     prev_flush,
  input  logic                     prev_stall,
  output logic                     stall,
  output logic                     flush,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [31:0]              dmem_addr,
  output logic [31:0]              dmem_wdata,
  output logic [3:0]               dmem_wstrb,
  input  logic                     dmem_ack,
  input  logic [31:0]              dmem_rdata,
  output logic                     clk_en,
  output logic [4:0]               rd,
  output logic [31:0]              rd_wdata,
  output logic                     rd_w_en,
  output logic [31:0]              pc,
  output logic                     load_misaligned,
  output logic                     store_misaligned,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        clk_en_q, clk_en_d, rd_w_en_q, rd_w_en_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rd_wdata_q, rd_wdata_d, pc_q, pc_d, hold_q, hold_d;
  logic        ld_mis_q, ld_mis_d, st_mis_q, st_mis_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        is_load_q, is_load_d, pend_we_q, pend_we_d;

  logic        is_ld, is_st, mis_ld, mis_st;
  logic [31:0] st_wdata, done_data;
  logic [3:0]  st_wstrb;
  logic        unused_opcode;

  assign unused_opcode = ^prev_opcode_type;

  // Pick the byte/half lane of a read word and extend it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                           input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'd0, b};
      3'b101:  fmt_load = {16'd0, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Decode access type, alignment and store lane replication.
  always_comb begin
    is_ld  = prev_opcode_type[`LOAD];
    is_st  = prev_opcode_type[`STORE];
    mis_ld = is_ld && (((prev_funct3[1:0] == 2'b01) && prev_alu_result[0]) ||
                       ((prev_funct3 == 3'b010) && (prev_alu_result[1:0] != 2'b00)));
    mis_st = is_st && (((prev_funct3 == 3'b001) && prev_alu_result[0]) ||
                       ((prev_funct3 == 3'b010) && (prev_alu_result[1:0] != 2'b00)));
    case (prev_funct3)
      3'b000: begin
        st_wdata = {4{prev_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << prev_alu_result[1:0];
      end
      3'b001: begin
        st_wdata = {2{prev_rs2_data[15:0]}};
        st_wstrb = prev_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = prev_rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
    done_data = is_load_q ? fmt_load(f3_q, off_q, dmem_rdata) : rd_wdata_q;
  end

  // Next-state and next-output logic for the access FSM.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    clk_en_d   = clk_en_q;
    rd_d       = rd_q;
    rd_wdata_d = rd_wdata_q;
    rd_w_en_d  = rd_w_en_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    ld_mis_d   = ld_mis_q;
    st_mis_d   = st_mis_q;
    f3_d       = f3_q;
    off_d      = off_q;
    is_load_d  = is_load_q;
    pend_we_d  = pend_we_q;
    case (state_q)
      IDLE: begin
        // A stalled writeback keeps the current result on the outputs.
        if (!prev_stall) begin
          clk_en_d = 1'b0;
          ld_mis_d = 1'b0;
          st_mis_d = 1'b0;
          if (prev_clk_en && !prev_flush) begin
            rd_d       = prev_rd;
            pc_d       = prev_pc;
            rd_wdata_d = prev_rd_wdata;
            if (!stall_from_alu) begin
              clk_en_d  = 1'b1;
              rd_w_en_d = prev_rd_w_en;
            end else if (mis_ld || mis_st) begin
              clk_en_d  = 1'b1;
              rd_w_en_d = 1'b0;
              ld_mis_d  = mis_ld;
              st_mis_d  = mis_st;
            end else begin
              state_d   = BUSY;
              req_d     = 1'b1;
              we_d      = !is_ld;
              addr_d    = {prev_alu_result[31:2], 2'b00};
              wdata_d   = st_wdata;
              wstrb_d   = is_ld ? 4'b0000 : st_wstrb;
              f3_d      = prev_funct3;
              off_d     = prev_alu_result[1:0];
              is_load_d = is_ld;
              pend_we_d = is_ld && prev_rd_w_en;
              rd_w_en_d = 1'b0;
            end
          end
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          if (!prev_stall) begin
            state_d    = IDLE;
            clk_en_d   = 1'b1;
            rd_wdata_d = done_data;
            rd_w_en_d  = pend_we_q;
          end else begin
            state_d = HOLD;
            hold_d  = done_data;
          end
        end
      end
      HOLD: begin
        if (!prev_stall) begin
          state_d    = IDLE;
          clk_en_d   = 1'b1;
          rd_wdata_d = hold_q;
          rd_w_en_d  = pend_we_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      clk_en_q   <= 1'b0;
      rd_q       <= '0;
      rd_wdata_q <= '0;
      rd_w_en_q  <= 1'b0;
      pc_q       <= '0;
      hold_q     <= '0;
      ld_mis_q   <= 1'b0;
      st_mis_q   <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      is_load_q  <= 1'b0;
      pend_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      clk_en_q   <= clk_en_d;
      rd_q       <= rd_d;
      rd_wdata_q <= rd_wdata_d;
      rd_w_en_q  <= rd_w_en_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      ld_mis_q   <= ld_mis_d;
      st_mis_q   <= st_mis_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      is_load_q  <= is_load_d;
      pend_we_q  <= pend_we_d;
    end
  end

  assign stall            = (state_q != IDLE) || prev_stall;
  assign flush            = prev_flush;
  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_wstrb       = wstrb_q;
  assign clk_en           = clk_en_q;
  assign rd               = rd_q;
  assign rd_wdata         = rd_wdata_q;
  assign rd_w_en          = rd_w_en_q;
  assign pc               = pc_q;
  assign load_misaligned  = ld_mis_q;
  assign store_misaligned = st_mis_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stores, loads, misalignment, writeback
// stall, flush and reset during an access.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD
`define LOAD 2
`endif
`ifndef STORE
`define STORE 3
`endif

module tb_mem_access;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [`OPCODE_WIDTH-1:0] prev_opcode_type;
  logic                     stall_from_alu;
  logic [31:0]              prev_alu_result, prev_rs2_data, prev_rd_wdata, prev_pc;
  logic [2:0]               prev_funct3;
  logic [4:0]               prev_rd;
  logic                     prev_rd_w_en, prev_clk_en, prev_flush, prev_stall;
  logic                     stall, flush, dmem_req, dmem_we, dmem_ack;
  logic [31:0]              dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]               dmem_wstrb;
  logic                     clk_en, rd_w_en, load_misaligned, store_misaligned;
  logic [4:0]               rd;
  logic [31:0]              rd_wdata, pc;
  logic [1:0]               dbg_state;

  int checks = 0;
  int errors = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .prev_opcode_type(prev_opcode_type),
    .stall_from_alu(stall_from_alu), .prev_alu_result(prev_alu_result),
    .prev_rs2_data(prev_rs2_data), .prev_funct3(prev_funct3), .prev_rd(prev_rd),
    .prev_rd_wdata(prev_rd_wdata), .prev_rd_w_en(prev_rd_w_en), .prev_pc(prev_pc),
    .prev_clk_en(prev_clk_en), .prev_flush(prev_flush), .prev_stall(prev_stall),
    .stall(stall), .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .clk_en(clk_en), .rd(rd),
    .rd_wdata(rd_wdata), .rd_w_en(rd_w_en), .pc(pc),
    .load_misaligned(load_misaligned), .store_misaligned(store_misaligned),
    .dbg_state(dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from the ALU stage.
  task automatic drive(input logic mem, input logic ld, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [2:0] f3, input logic [4:0] rdi,
                       input logic [31:0] rdw, input logic wen, input logic [31:0] pcv);
    prev_opcode_type = '0;
    if (mem) begin
      if (ld) prev_opcode_type[`LOAD] = 1'b1;
      else    prev_opcode_type[`STORE] = 1'b1;
    end
    stall_from_alu  = mem;
    prev_alu_result = addr;
    prev_rs2_data   = rs2;
    prev_funct3     = f3;
    prev_rd         = rdi;
    prev_rd_wdata   = rdw;
    prev_rd_w_en    = wen;
    prev_pc         = pcv;
    prev_clk_en     = 1'b1;
  endtask

  task automatic idle_in();
    prev_clk_en    = 1'b0;
    stall_from_alu = 1'b0;
    prev_flush     = 1'b0;
    prev_opcode_type = '0;
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0; prev_stall = 1'b0;
    prev_alu_result = '0; prev_rs2_data = '0; prev_funct3 = '0; prev_rd = '0;
    prev_rd_wdata = '0; prev_rd_w_en = 1'b0; prev_pc = '0;
    idle_in();
    tick(); tick();
    rst = 1'b0;
    check("rst_clk_en", clk_en, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_rd_wdata", rd_wdata, 0);
    check("rst_state", dbg_state, 0);
    check("rst_stall", stall, 0);

    // SW 0x100, ack on the third request cycle.
    drive(1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 5'd0, 32'h0, 1'b0, 32'h40);
    tick(); idle_in();
    check("sw_req1", dmem_req, 1);
    check("sw_we", dmem_we, 1);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check("sw_wstrb", dmem_wstrb, 4'b1111);
    check("sw_stall", stall, 1);
    check("sw_clk_en_busy", clk_en, 0);
    tick();
    check("sw_req2", dmem_req, 1);
    check("sw_wdata_stable", dmem_wdata, 32'hDEADBEEF);
    tick();
    check("sw_req3", dmem_req, 1);
    dmem_ack = 1'b1;
    tick(); dmem_ack = 1'b0;
    check("sw_req_done", dmem_req, 0);
    check("sw_clk_en", clk_en, 1);
    check("sw_rd_w_en", rd_w_en, 0);
    check("sw_stall_done", stall, 0);
    tick();
    check("sw_clk_en_drop", clk_en, 0);

    // LB 0x203, ack in the first request cycle.
    drive(1, 1, 32'h203, 32'h0, 3'b000, 5'd5, 32'h0, 1'b1, 32'h44);
    tick(); idle_in();
    check("lb_req", dmem_req, 1);
    check("lb_we", dmem_we, 0);
    check("lb_wstrb", dmem_wstrb, 0);
    check("lb_addr", dmem_addr, 32'h200);
    dmem_ack = 1'b1; dmem_rdata = 32'h80123456;
    tick(); dmem_ack = 1'b0;
    check("lb_clk_en", clk_en, 1);
    check("lb_data", rd_wdata, 32'hFFFFFF80);
    check("lb_rd", rd, 5);
    check("lb_rd_w_en", rd_w_en, 1);
    check("lb_pc", pc, 32'h44);
    check("lb_req_done", dmem_req, 0);

    // LHU 0x202.
    drive(1, 1, 32'h202, 32'h0, 3'b101, 5'd6, 32'h0, 1'b1, 32'h48);
    tick(); idle_in();
    dmem_ack = 1'b1; dmem_rdata = 32'hBEEF1234;
    tick(); dmem_ack = 1'b0;
    check("lhu_data", rd_wdata, 32'h0000BEEF);
    check("lhu_clk_en", clk_en, 1);

    // SB 0x001.
    drive(1, 0, 32'h001, 32'h000000AB, 3'b000, 5'd0, 32'h0, 1'b0, 32'h4C);
    tick(); idle_in();
    check("sb_wdata", dmem_wdata, 32'hABABABAB);
    check("sb_wstrb", dmem_wstrb, 4'b0010);
    check("sb_addr", dmem_addr, 32'h0);
    dmem_ack = 1'b1;
    tick(); dmem_ack = 1'b0;
    check("sb_clk_en", clk_en, 1);

    // SH 0x102 selects the upper half lanes.
    drive(1, 0, 32'h102, 32'h0000CAFE, 3'b001, 5'd0, 32'h0, 1'b0, 32'h4E);
    tick(); idle_in();
    check("sh_wdata", dmem_wdata, 32'hCAFECAFE);
    check("sh_wstrb", dmem_wstrb, 4'b1100);
    dmem_ack = 1'b1;
    tick(); dmem_ack = 1'b0;

    // Misaligned LW 0x1002.
    drive(1, 1, 32'h1002, 32'h0, 3'b010, 5'd7, 32'h0, 1'b1, 32'h50);
    tick(); idle_in();
    check("lwmis_req", dmem_req, 0);
    check("lwmis_flag", load_misaligned, 1);
    check("lwmis_st_flag", store_misaligned, 0);
    check("lwmis_clk_en", clk_en, 1);
    check("lwmis_rd_w_en", rd_w_en, 0);
    tick();
    check("lwmis_flag_drop", load_misaligned, 0);
    check("lwmis_req_never", dmem_req, 0);

    // Misaligned SH 0x003.
    drive(1, 0, 32'h003, 32'h1234, 3'b001, 5'd0, 32'h0, 1'b0, 32'h54);
    tick(); idle_in();
    check("shmis_flag", store_misaligned, 1);
    check("shmis_req", dmem_req, 0);
    tick();

    // LH 0x102 with writeback stalled at ack.
    drive(1, 1, 32'h102, 32'h0, 3'b001, 5'd8, 32'h0, 1'b1, 32'h58);
    tick(); idle_in();
    dmem_ack = 1'b1; dmem_rdata = 32'h80017FFF; prev_stall = 1'b1;
    tick(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    check("hold_state", dbg_state, 2);
    check("hold_req", dmem_req, 0);
    check("hold_clk_en", clk_en, 0);
    check("hold_stall", stall, 1);
    tick();
    check("hold_clk_en2", clk_en, 0);
    prev_stall = 1'b0;
    tick();
    check("hold_out_clk_en", clk_en, 1);
    check("hold_out_data", rd_wdata, 32'hFFFF8001);
    check("hold_out_state", dbg_state, 0);

    // Non-memory instruction, then an idle writeback stall holds outputs.
    drive(0, 0, 32'h0, 32'h0, 3'b000, 5'd3, 32'h12345678, 1'b1, 32'h80);
    tick(); idle_in();
    check("alu_clk_en", clk_en, 1);
    check("alu_data", rd_wdata, 32'h12345678);
    check("alu_rd", rd, 3);
    check("alu_pc", pc, 32'h80);
    check("alu_req", dmem_req, 0);
    prev_stall = 1'b1;
    tick();
    check("idle_hold_clk_en", clk_en, 1);
    check("idle_hold_data", rd_wdata, 32'h12345678);
    prev_stall = 1'b0;
    tick();
    check("idle_release", clk_en, 0);

    // Flush at accept of a store.
    drive(1, 0, 32'h200, 32'h55, 3'b010, 5'd0, 32'h0, 1'b0, 32'h84);
    prev_flush = 1'b1;
    #1;
    check("flush_out", flush, 1);
    tick(); idle_in();
    check("flush_req", dmem_req, 0);
    check("flush_clk_en", clk_en, 0);

    // Reset during BUSY, then a late ack.
    drive(1, 1, 32'h300, 32'h0, 3'b010, 5'd9, 32'h0, 1'b1, 32'h88);
    tick(); idle_in();
    check("rstbusy_req", dmem_req, 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("rstbusy_req_drop", dmem_req, 0);
    check("rstbusy_clk_en", clk_en, 0);
    check("rstbusy_state", dbg_state, 0);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    tick(); dmem_ack = 1'b0;
    check("late_ack_clk_en", clk_en, 0);
    check("late_ack_req", dmem_req, 0);
    check("late_ack_data", rd_wdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
